// File: rtl/video_modulator_pkg.sv
// Shared constants for the composite/S-video modulator phase path.
package video_modulator_pkg;

    localparam int PHASE_W = 9;

    // V axis lags U by 90 degrees (128 of 512 steps).
    localparam logic [PHASE_W-1:0] SIN_OFS = 9'd128;

    // Burst phase offsets relative to the U-axis phase.
    localparam logic [PHASE_W-1:0] BURST_OFS_NTSC    = 9'd256; // 180 deg
    localparam logic [PHASE_W-1:0] BURST_OFS_PAL_POS = 9'd192; // 135 deg
    localparam logic [PHASE_W-1:0] BURST_OFS_PAL_NEG = 9'd320; // 225 deg

endpackage

// File: rtl/video_modulator_phase_gen_if.sv
// Line-timing inputs and subcarrier phase outputs of the phase generator.
//
// There is no handshake on this bus: the slave samples line_start,
// frame_start and pal_mode on every rising clock edge (a pulse held for
// N cycles counts as N events), and every output is a register that is
// valid on every cycle.
interface video_modulator_phase_gen_if;
    import video_modulator_pkg::*;

    logic               line_start;
    logic               frame_start;
    logic               pal_mode;
    logic [PHASE_W-1:0] phase_cos;
    logic [PHASE_W-1:0] phase_sin;
    logic [PHASE_W-1:0] burst_phase;
    logic               burst_en;
    logic               vswitch;

    // Timing generator side.
    modport master (
        output line_start, frame_start, pal_mode,
        input  phase_cos, phase_sin, burst_phase, burst_en, vswitch
    );

    // Phase generator side.
    modport slave (
        input  line_start, frame_start, pal_mode,
        output phase_cos, phase_sin, burst_phase, burst_en, vswitch
    );
endinterface

// File: rtl/video_modulator_burst_gate.sv
// Horizontal position counter and colour-burst gate window.
module video_modulator_burst_gate #(
    parameter int BURST_START = 132,
    parameter int BURST_LEN   = 63
) (
    input  logic clk,
    input  logic rst,
    input  logic line_start_i,
    output logic burst_en_o
);
    localparam int WIN_END = BURST_START + BURST_LEN;

    // The saturated count (2047) must never fall inside the window.
    if (WIN_END > 2047) begin : g_bad_window
        $error("burst window end exceeds the 11-bit line counter");
    end

    localparam logic [11:0] WIN_START_W = 12'(BURST_START);
    localparam logic [11:0] WIN_END_W   = 12'(WIN_END);

    logic [10:0] hcnt_q;
    logic [10:0] hcnt_d;
    logic        burst_en_q;
    logic        burst_en_d;

    // Next count: restart on line_start, otherwise count up and stick at 2047.
    always_comb begin
        hcnt_d = hcnt_q;
        if (line_start_i) begin
            hcnt_d = 11'd0;
        end else if (hcnt_q != 11'd2047) begin
            hcnt_d = hcnt_q + 11'd1;
        end
        burst_en_d = ({1'b0, hcnt_d} >= WIN_START_W) && ({1'b0, hcnt_d} < WIN_END_W);
    end

    // Counter and registered gate; reset parks the counter outside the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q     <= 11'd2047;
            burst_en_q <= 1'b0;
        end else begin
            hcnt_q     <= hcnt_d;
            burst_en_q <= burst_en_d;
        end
    end

    assign burst_en_o = burst_en_q;
endmodule

// File: rtl/video_modulator_phase_gen.sv
// Colour-subcarrier NCO: U/V/burst phases, PAL V-switch and burst gate.
module video_modulator_phase_gen
    import video_modulator_pkg::*;
#(
    parameter logic [31:0] PHASE_INC   = 32'd614961227,
    parameter int          BURST_START = 132,
    parameter int          BURST_LEN   = 63
) (
    input  logic                        clk,
    input  logic                        rst,
    video_modulator_phase_gen_if.slave  vid
);
    logic [31:0]        acc_q;
    logic [31:0]        nacc;
    logic [PHASE_W-1:0] phase_nxt;
    logic [PHASE_W-1:0] burst_ofs;
    logic               vswitch_d;
    logic               vswitch_q;
    logic [PHASE_W-1:0] phase_cos_q;
    logic [PHASE_W-1:0] phase_sin_q;
    logic [PHASE_W-1:0] burst_phase_q;
    logic               burst_en;

    // Next accumulator value, next V-switch and the burst offset it selects.
    always_comb begin
        nacc      = acc_q + PHASE_INC;
        phase_nxt = nacc[31:23];

        vswitch_d = vswitch_q;
        if (!vid.pal_mode || vid.frame_start) begin
            vswitch_d = 1'b0;
        end else if (vid.line_start) begin
            vswitch_d = ~vswitch_q;
        end

        // pal_mode switches the offset at once, even before V-switch restarts.
        burst_ofs = BURST_OFS_NTSC;
        if (vid.pal_mode) begin
            burst_ofs = vswitch_d ? BURST_OFS_PAL_POS : BURST_OFS_PAL_NEG;
        end
    end

    // Free-running accumulator (never realigned to line or field) and the
    // three cycle-aligned phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q         <= 32'd0;
            vswitch_q     <= 1'b0;
            phase_cos_q   <= 9'd0;
            phase_sin_q   <= 9'd384;
            burst_phase_q <= 9'd256;
        end else begin
            acc_q         <= nacc;
            vswitch_q     <= vswitch_d;
            phase_cos_q   <= phase_nxt;
            phase_sin_q   <= phase_nxt - SIN_OFS;
            burst_phase_q <= phase_nxt + burst_ofs;
        end
    end

    video_modulator_burst_gate #(
        .BURST_START (BURST_START),
        .BURST_LEN   (BURST_LEN)
    ) u_burst_gate (
        .clk          (clk),
        .rst          (rst),
        .line_start_i (vid.line_start),
        .burst_en_o   (burst_en)
    );

    assign vid.phase_cos   = phase_cos_q;
    assign vid.phase_sin   = phase_sin_q;
    assign vid.burst_phase = burst_phase_q;
    assign vid.burst_en    = burst_en;
    assign vid.vswitch     = vswitch_q;
endmodule
